// File: rtl/tekipaki_snd_out_if.sv
// Sample-stream bundle between the FM core and the game-level audio outputs.
interface tekipaki_snd_out_if;
  logic signed [15:0] IN_SAMPLE;
  logic               IN_VALID;
  logic [1:0]         FM_LEVEL;
  logic               FM_EN;
  logic               DIP_PAUSE;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               sample;
  logic               peak;

  modport master (
    output IN_SAMPLE, IN_VALID, FM_LEVEL, FM_EN, DIP_PAUSE,
    input  left, right, sample, peak
  );

  modport slave (
    input  IN_SAMPLE, IN_VALID, FM_LEVEL, FM_EN, DIP_PAUSE,
    output left, right, sample, peak
  );
endinterface

// File: rtl/tekipaki_snd_out.sv
// FM output conditioner: DC-block, level gain, saturation/peak and mute fade,
// as a 3-stage pipeline producing identical left/right channels.
module tekipaki_snd_out #(
  parameter int DC_SHIFT = 8,
  parameter int FADE_MAX = 16
) (
  input logic              CLK,
  input logic              RESET,
  tekipaki_snd_out_if.slave snd
);

  localparam logic [4:0] F_FULL = 5'(FADE_MAX);

  logic signed [23:0] y;
  logic signed [15:0] x_prev;
  logic signed [15:0] d1;
  logic               sat1;
  logic               v1;
  logic signed [15:0] g;
  logic               satg;
  logic               v2;
  logic [4:0]         f;
  logic signed [15:0] out_q;
  logic               sample_q;
  logic               peak_q;

  logic signed [23:0] y_leak;
  logic signed [25:0] y_sum;
  logic signed [23:0] y_next;
  logic signed [15:0] d1_next;
  logic               sat1_next;
  logic signed [18:0] d1x;
  logic signed [18:0] g19;
  logic signed [15:0] g_next;
  logic               clamp_g;
  logic signed [20:0] prod;
  logic signed [15:0] fade_out;
  logic [4:0]         f_target;
  logic [4:0]         f_next;

  // Stage 1: the accumulator is clamped to 24 bits so it can never wrap.
  assign y_leak = y >>> DC_SHIFT;
  assign y_sum  = $signed({{10{snd.IN_SAMPLE[15]}}, snd.IN_SAMPLE})
                - $signed({{10{x_prev[15]}}, x_prev})
                + $signed({{2{y[23]}}, y})
                - $signed({{2{y_leak[23]}}, y_leak});

  always_comb begin
    y_next = y_sum[23:0];
    if (y_sum > 26'sd8388607)
      y_next = 24'sh7FFFFF;
    else if (y_sum < -26'sd8388608)
      y_next = 24'sh800000;

    d1_next   = y_next[15:0];
    sat1_next = 1'b0;
    if (y_next > 24'sd32767) begin
      d1_next   = 16'sh7FFF;
      sat1_next = 1'b1;
    end else if (y_next < -24'sd32768) begin
      d1_next   = 16'sh8000;
      sat1_next = 1'b1;
    end
  end

  // Stage 2: gain is done at 19 bits so a x4 of any 16-bit value fits before clamping.
  assign d1x = {{3{d1[15]}}, d1};

  always_comb begin
    case (snd.FM_LEVEL)
      2'd0:    g19 = d1x >>> 1;
      2'd1:    g19 = d1x;
      2'd2:    g19 = d1x <<< 1;
      default: g19 = d1x <<< 2;
    endcase

    g_next  = g19[15:0];
    clamp_g = 1'b0;
    if (g19 > 19'sd32767) begin
      g_next  = 16'sh7FFF;
      clamp_g = 1'b1;
    end else if (g19 < -19'sd32768) begin
      g_next  = 16'sh8000;
      clamp_g = 1'b1;
    end
  end

  // Stage 3: fade scale uses the current F; F then walks one step toward its target.
  assign prod     = $signed({{5{g[15]}}, g}) * $signed({16'd0, f});
  assign fade_out = 16'(prod >>> 4);
  assign f_target = (snd.DIP_PAUSE | ~snd.FM_EN) ? 5'd0 : F_FULL;

  always_comb begin
    f_next = f;
    if (f < f_target)
      f_next = f + 5'd1;
    else if (f > f_target)
      f_next = f - 5'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      y        <= '0;
      x_prev   <= '0;
      d1       <= '0;
      sat1     <= 1'b0;
      v1       <= 1'b0;
      g        <= '0;
      satg     <= 1'b0;
      v2       <= 1'b0;
      f        <= F_FULL;
      out_q    <= '0;
      sample_q <= 1'b0;
      peak_q   <= 1'b0;
    end else begin
      v1       <= snd.IN_VALID;
      v2       <= v1;
      sample_q <= v2;
      if (snd.IN_VALID) begin
        y      <= y_next;
        x_prev <= snd.IN_SAMPLE;
        d1     <= d1_next;
        sat1   <= sat1_next;
      end
      if (v1) begin
        g    <= g_next;
        satg <= sat1 | clamp_g;
      end
      if (v2) begin
        out_q  <= fade_out;
        peak_q <= satg;
        f      <= f_next;
      end
    end
  end

  assign snd.left   = out_q;
  assign snd.right  = out_q;
  assign snd.sample = sample_q;
  assign snd.peak   = peak_q;

endmodule

// File: tb/tb_tekipaki_snd_out.sv
// Directed bench for tekipaki_snd_out: hand-computed vector table plus
// multi-cycle sequences (back-to-back, fades, reset mid-pipe) against a small model.
module tb_tekipaki_snd_out;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  tekipaki_snd_out_if sif();

  tekipaki_snd_out dut (
    .CLK   (CLK),
    .RESET (RESET),
    .snd   (sif)
  );

  typedef struct {
    logic        doRst;
    logic [15:0] x;
    logic [1:0]  lvl;
    logic [15:0] expOut;
    logic        expPeak;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int ym, xpm, fm;

  function automatic int clampTo(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic modelReset();
    ym  = 0;
    xpm = 0;
    fm  = 16;
  endtask

  // Behavioural model of one sample, in plain integer arithmetic.
  task automatic modelStep(input logic [15:0] xin, input int lvl, input bit mute,
                           output int out, output bit pk);
    int x, yn, d, g, gs;
    x   = int'($signed(xin));
    yn  = clampTo(x - xpm + ym - (ym >>> 8), -8388608, 8388607);
    ym  = yn;
    xpm = x;
    d   = clampTo(yn, -32768, 32767);
    case (lvl)
      0:       g = d >>> 1;
      1:       g = d;
      2:       g = d * 2;
      default: g = d * 4;
    endcase
    gs  = clampTo(g, -32768, 32767);
    pk  = (d != yn) || (gs != g);
    out = (gs * fm) >>> 4;
    if (mute && fm > 0) fm = fm - 1;
    else if (!mute && fm < 16) fm = fm + 1;
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int expOut, input bit expPeak);
    checkVal({name, "_sample"}, int'(sif.sample), 1);
    checkVal({name, "_left"}, int'($signed(sif.left)), expOut);
    checkVal({name, "_right"}, int'($signed(sif.right)), expOut);
    checkVal({name, "_peak"}, int'(sif.peak), int'(expPeak));
  endtask

  task automatic doReset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    modelReset();
  endtask

  // One isolated sample: strobe, confirm 3-cycle latency, check, confirm hold.
  task automatic applyStimulus(input string name, input logic [15:0] x,
                               input int expOut, input bit expPeak);
    sif.IN_SAMPLE = x;
    sif.IN_VALID  = 1'b1;
    @(posedge CLK); #1;
    sif.IN_VALID  = 1'b0;
    checkVal({name, "_lat1"}, int'(sif.sample), 0);
    @(posedge CLK); #1;
    checkVal({name, "_lat2"}, int'(sif.sample), 0);
    @(posedge CLK); #1;
    checkOutput(name, expOut, expPeak);
    @(posedge CLK); #1;
    checkVal({name, "_strobe_end"}, int'(sif.sample), 0);
    checkVal({name, "_hold"}, int'($signed(sif.left)), expOut);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    logic [15:0] bvals[8];
    int bexp[8];
    bit bpk[8];
    int mo;
    bit mp;

    vecs[0]  = '{1'b0, 16'h1000, 2'd1, 16'h1000, 1'b0};
    vecs[1]  = '{1'b0, 16'h1000, 2'd1, 16'h0FF0, 1'b0};
    vecs[2]  = '{1'b0, 16'h1000, 2'd1, 16'h0FE1, 1'b0};
    vecs[3]  = '{1'b0, 16'h1000, 2'd1, 16'h0FD2, 1'b0};
    vecs[4]  = '{1'b1, 16'h3000, 2'd3, 16'h7FFF, 1'b1};
    vecs[5]  = '{1'b1, 16'hD000, 2'd3, 16'h8000, 1'b1};
    vecs[6]  = '{1'b1, 16'h3000, 2'd0, 16'h1800, 1'b0};
    vecs[7]  = '{1'b1, 16'h3000, 2'd2, 16'h6000, 1'b0};
    vecs[8]  = '{1'b1, 16'h7FFF, 2'd1, 16'h7FFF, 1'b0};
    vecs[9]  = '{1'b0, 16'h8000, 2'd1, 16'h8000, 1'b1};
    vecs[10] = '{1'b1, 16'h8000, 2'd1, 16'h8000, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFF, 2'd0, 16'hFFFF, 1'b0};
    vecs[12] = '{1'b1, 16'h4000, 2'd1, 16'h4000, 1'b0};
    vecs[13] = '{1'b0, 16'h4000, 2'd2, 16'h7F80, 1'b0};

    sif.IN_SAMPLE = 16'h1234;
    sif.IN_VALID  = 1'b1;
    sif.FM_LEVEL  = 2'd1;
    sif.FM_EN     = 1'b1;
    sif.DIP_PAUSE = 1'b0;
    RESET         = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET        = 1'b0;
    sif.IN_VALID = 1'b0;
    modelReset();
    for (int c = 0; c < 3; c++) begin
      checkVal($sformatf("rst_sample_c%0d", c), int'(sif.sample), 0);
      checkVal($sformatf("rst_left_c%0d", c), int'($signed(sif.left)), 0);
      checkVal($sformatf("rst_right_c%0d", c), int'($signed(sif.right)), 0);
      checkVal($sformatf("rst_peak_c%0d", c), int'(sif.peak), 0);
      @(posedge CLK); #1;
    end

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].doRst) doReset();
      sif.FM_LEVEL = vecs[i].lvl;
      applyStimulus($sformatf("vec%0d", i), vecs[i].x,
                    int'($signed(vecs[i].expOut)), vecs[i].expPeak);
    end

    // Back-to-back: 8 consecutive strobes must come out on 8 consecutive cycles.
    doReset();
    sif.FM_LEVEL = 2'd1;
    bvals = '{16'h0100, 16'h0200, 16'hFF00, 16'h1234, 16'h8000, 16'h7FFF, 16'h0000, 16'h0050};
    for (int i = 0; i < 8; i++) modelStep(bvals[i], 1, 1'b0, bexp[i], bpk[i]);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sif.IN_SAMPLE = bvals[i];
          sif.IN_VALID  = 1'b1;
          @(posedge CLK); #1;
        end
        sif.IN_VALID = 1'b0;
      end
      begin
        for (int c = 0; c < 3; c++) begin
          checkVal($sformatf("b2b_lat%0d", c), int'(sif.sample), 0);
          @(posedge CLK); #1;
        end
        for (int i = 0; i < 8; i++) begin
          checkOutput($sformatf("b2b%0d", i), bexp[i], bpk[i]);
          @(posedge CLK); #1;
        end
        checkVal("b2b_after", int'(sif.sample), 0);
      end
    join

    // Fade out on DIP_PAUSE, ramp back, then fade out on FM_EN.
    doReset();
    sif.FM_LEVEL  = 2'd1;
    sif.DIP_PAUSE = 1'b1;
    for (int k = 0; k < 18; k++) begin
      modelStep(16'h0400, 1, 1'b1, mo, mp);
      applyStimulus($sformatf("pause_dn%0d", k), 16'h0400, mo, mp);
      if (k >= 16) checkVal($sformatf("pause_zero%0d", k), int'($signed(sif.left)), 0);
    end
    sif.DIP_PAUSE = 1'b0;
    for (int k = 0; k < 17; k++) begin
      modelStep(16'h0400, 1, 1'b0, mo, mp);
      applyStimulus($sformatf("pause_up%0d", k), 16'h0400, mo, mp);
      if (k == 0) checkVal("pause_up_first_zero", int'($signed(sif.left)), 0);
    end
    sif.FM_EN = 1'b0;
    for (int k = 0; k < 18; k++) begin
      modelStep(16'h0400, 1, 1'b1, mo, mp);
      applyStimulus($sformatf("fmen_dn%0d", k), 16'h0400, mo, mp);
      if (k >= 16) checkVal($sformatf("fmen_zero%0d", k), int'($signed(sif.left)), 0);
    end
    sif.FM_EN = 1'b1;

    // Reset one cycle after a strobe: the in-flight sample must vanish.
    sif.IN_SAMPLE = 16'h2000;
    sif.IN_VALID  = 1'b1;
    @(posedge CLK); #1;
    sif.IN_VALID = 1'b0;
    doReset();
    for (int c = 0; c < 3; c++) begin
      checkVal($sformatf("midrst_nostrobe%0d", c), int'(sif.sample), 0);
      @(posedge CLK); #1;
    end
    applyStimulus("midrst_next", 16'h1000, 4096, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
